unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the Fetch-stage instruction port and the Memory-stage data port of the pipelined core.
- Sequences one memory transaction at a time using a req/ack handshake.
- Returns read data and a one-cycle ready pulse to the winning port, and drives per-port stall requests to the hazard unit.
- Data has priority; a streak counter bounds instruction-fetch starvation.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DSTREAK, 4, max consecutive data grants while a fetch is pending

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- InstrReqF  in  1  fetch request
- PCF  in  ADDR_W  fetch address
- InstrF  out  DATA_W  fetched instruction, valid when InstrRdyF=1
- InstrRdyF  out  1  one-cycle fetch-complete pulse
- StallInstrF  out  1  InstrReqF & ~InstrRdyF
- DataReqM  in  1  load/store request (MemtoRegM | MemWriteM)
- MemWriteM  in  1  1=store, 0=load
- ALUOutM  in  ADDR_W  data address
- WriteDataM  in  DATA_W  store data
- ReadDataM  out  DATA_W  load data, valid when DataRdyM=1
- DataRdyM  out  1  one-cycle data-complete pulse
- StallDataM  out  1  DataReqM & ~DataRdyM
- MemReq  out  1  memory request
- MemWe  out  1  memory write enable
- MemAddr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- MemWData  out  DATA_W  write data
- MemRData  in  DATA_W  memory read data, valid with MemAck
- MemAck  in  1  transaction complete

Behaviour:
- States: IDLE, IBUSY, DBUSY, DONE.
- Reset (async, reset=0):
  - State=IDLE; MemReq=0, MemWe=0, MemAddr=0, MemWData=0.
  - InstrF=0, ReadDataM=0, InstrRdyF=0, DataRdyM=0.
  - Streak counter=0.
  - Reset mid-transaction abandons it; a subsequent stray MemAck is ignored.
- IDLE arbitration (sampled at clock edge):
  - DataReqM & (~InstrReqF | streak<MAX_DSTREAK) -> DBUSY.
  - Otherwise, if InstrReqF -> IBUSY.
  - Otherwise stay in IDLE.
- Grant registration:
  - Address, We and WData for the granted port are registered into MemAddr/MemWe/MemWData on the grant edge.
  - MemWe=MemWriteM for data, 0 for fetch.
- MemReq=1 exactly in IBUSY/DBUSY. MemAddr/MemWe/MemWData stay stable until the ack edge.
- IBUSY/DBUSY: on a MemAck=1 edge:
  - Capture MemRData into InstrF or ReadDataM. For a store, ReadDataM keeps its previous value.
  - Go to DONE and raise the matching Rdy for exactly one cycle (the DONE cycle).
- DONE: always -> IDLE. Requests are ignored in DONE, so a port still holding its request in its Rdy cycle is not re-served.
- Latency:
  - Request seen at edge N -> MemReq high from N+1.
  - Ack sampled at edge N+1+k (k>=0 wait cycles) -> Rdy high in cycle N+2+k.
  - Minimum 3 cycles request-to-Rdy; back-to-back issue every 3+k cycles.
- MemAck in IDLE/DONE is ignored.
- A request deasserted mid-transaction does not abort: the transaction completes and Rdy still pulses.
- Streak counter:
  - Increment (saturating at MAX_DSTREAK) on a data grant while InstrReqF=1.
  - Clear on any instruction grant, or on a data grant with InstrReqF=0.
- Stall outputs are combinational from request inputs and registered Rdy outputs.
- Only one of InstrRdyF/DataRdyM is ever high in a cycle.

Decomposition:
- Shared package holds:
  - arb_state_t enum (IDLE, IBUSY, DBUSY, DONE)
  - arb_port_t enum (PORT_I, PORT_D)
  - a default MAX_DSTREAK constant
- Natural sub-module: streak_counter, a saturating counter with inc/clr and a "limit reached" output.
- Everything else lives in one module.

Test Plan:
- Reset held 0, MemAck toggling -> all outputs 0, MemReq stays 0. Release, no requests -> stays IDLE.
- InstrReqF=1, PCF=0x1006, ack after k=2 with MemRData=0xE2811001:
  - MemAddr=0x1004, MemWe=0.
  - InstrRdyF pulses once in cycle 5 after the request with InstrF=0xE2811001.
  - StallInstrF=1 until then.
- InstrReqF=1 and DataReqM=1 (store, ALUOutM=0x20, WriteDataM=0xCAFE) in the same cycle, k=0:
  - Data is served first with MemWe=1, MemWData=0xCAFE.
  - DataRdyM pulses, then the fetch is served next.
- DataReqM held 1 continuously with InstrReqF=1, MAX_DSTREAK=4, k=0 -> exactly 4 data grants, then 1 instruction grant, then data again.
- Load issued, reset pulsed low while in DBUSY, then MemAck=1 arrives -> MemReq drops immediately, no DataRdyM pulse, state IDLE.
- MemAck=1 asserted while IDLE with no request -> no Rdy pulse, no state change, no MemReq.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

  localparam int unsigned DEF_MAX_DSTREAK = 4;

endpackage

// File: rtl/unified_mem_arbiter_streak_counter.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module unified_mem_arbiter_streak_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = DEF_MAX_DSTREAK
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic limit
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment, increment saturates at MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (inc && (cnt_q != CW'(MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit = (cnt_q == CW'(MAX));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the data port,
// one req/ack transaction at a time, with data priority and bounded fetch starvation.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = DEF_MAX_DSTREAK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InstrReqF,
  input  logic [ADDR_W-1:0] PCF,
  output logic [DATA_W-1:0] InstrF,
  output logic              InstrRdyF,
  output logic              StallInstrF,
  input  logic              DataReqM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              DataRdyM,
  output logic              StallDataM,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemAck
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              irdy_q, irdy_d;
  logic              drdy_q, drdy_d;
  logic              streak_inc_s;
  logic              streak_clr_s;
  logic              streak_limit_s;
  logic              unused_addr_lsbs_s;

  // Byte-offset bits never reach the word-addressed memory
  assign unused_addr_lsbs_s = ^{PCF[1:0], ALUOutM[1:0]};

  unified_mem_arbiter_streak_counter #(
    .MAX (MAX_DSTREAK)
  ) u_streak (
    .clk   (clk),
    .reset (reset),
    .inc   (streak_inc_s),
    .clr   (streak_clr_s),
    .limit (streak_limit_s)
  );

  // Arbitration, grant registration and ack capture
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    instr_d      = instr_q;
    rdata_d      = rdata_q;
    irdy_d       = 1'b0;
    drdy_d       = 1'b0;
    streak_inc_s = 1'b0;
    streak_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (DataReqM && (!InstrReqF || !streak_limit_s)) begin
          state_d      = DBUSY;
          addr_d       = {ALUOutM[ADDR_W-1:2], 2'b00};
          we_d         = MemWriteM;
          wdata_d      = WriteDataM;
          streak_inc_s = InstrReqF;
          streak_clr_s = !InstrReqF;
        end else if (InstrReqF) begin
          state_d      = IBUSY;
          addr_d       = {PCF[ADDR_W-1:2], 2'b00};
          we_d         = 1'b0;
          streak_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      IBUSY: begin
        if (MemAck) begin
          instr_d = MemRData;
          irdy_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = IBUSY;
        end
      end
      DBUSY: begin
        if (MemAck) begin
          // A store leaves the last load value in place
          if (!we_q) begin
            rdata_d = MemRData;
          end else begin
            rdata_d = rdata_q;
          end
          drdy_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = DBUSY;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      we_q    <= 1'b0;
      wdata_q <= {DATA_W{1'b0}};
      instr_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      irdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      irdy_q  <= irdy_d;
      drdy_q  <= drdy_d;
    end
  end

  assign MemReq      = (state_q == IBUSY) || (state_q == DBUSY);
  assign MemWe       = we_q;
  assign MemAddr     = addr_q;
  assign MemWData    = wdata_q;
  assign InstrF      = instr_q;
  assign ReadDataM   = rdata_q;
  assign InstrRdyF   = irdy_q;
  assign DataRdyM    = drdy_q;
  assign StallInstrF = InstrReqF & ~irdy_q;
  assign StallDataM  = DataReqM & ~drdy_q;

endmodule
